// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit over a word memory (optional macro: LSU_ALIGN_CHECK_EN)
`timescale 1ns/1ps
module load_store_unit #(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [1:0]            Req_Size,
  input  logic                  Req_Signed,
  input  logic [DATA_WIDTH-1:0] Req_Address,
  input  logic [DATA_WIDTH-1:0] Req_Wdata,
  output logic                  Rsp_Valid,
  output logic [DATA_WIDTH-1:0] Rsp_Data,
  output logic                  Rsp_Error,
  output logic                  Mem_Write_Enable,
  output logic [DATA_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DATA, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next_state;

  // Latched request fields and response registers
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_req_err;
  logic [DATA_WIDTH-1:0] w_word_idx;
  logic [DATA_WIDTH-1:0] w_addr_eff;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merge_data;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_accept   = Req_Valid && (r_state == S_IDLE);
  assign w_word_idx = Req_Address >> 2;

`ifdef LSU_ALIGN_CHECK_EN
  logic w_misaligned;

  // Misaligned half/word accesses are rejected
  always_comb begin
    w_misaligned = 1'b0;
    if (Req_Size == SZ_HALF) begin
      w_misaligned = Req_Address[0];
    end else if (Req_Size == SZ_WORD) begin
      w_misaligned = |Req_Address[1:0];
    end
  end

  assign w_addr_eff = Req_Address;
  assign w_req_err  = (Req_Size == SZ_RSVD) ||
                      (w_word_idx >= DATA_WIDTH'(MEMORY_DEPTH)) ||
                      w_misaligned;
`else
  // Misaligned half/word accesses are silently aligned down
  always_comb begin
    w_addr_eff = Req_Address;
    if (Req_Size == SZ_HALF) begin
      w_addr_eff[0] = 1'b0;
    end else if (Req_Size == SZ_WORD) begin
      w_addr_eff[1:0] = 2'b00;
    end
  end

  assign w_req_err = (Req_Size == SZ_RSVD) ||
                     (w_word_idx >= DATA_WIDTH'(MEMORY_DEPTH));
`endif

  // Extract the addressed lane of the read word and extend it
  always_comb begin
    w_byte      = Mem_Read_Data[{r_addr[1:0], 3'b000} +: 8];
    w_half      = Mem_Read_Data[{r_addr[1], 4'b0000} +: 16];
    w_load_data = Mem_Read_Data;
    case (r_size)
      SZ_BYTE: w_load_data = {{(DATA_WIDTH-8){r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{(DATA_WIDTH-16){r_signed & w_half[15]}}, w_half};
      default: w_load_data = Mem_Read_Data;
    endcase
  end

  // Read-modify-write: drop the store lane into the word just read
  always_comb begin
    w_merge_data = Mem_Read_Data;
    if (r_size == SZ_BYTE) begin
      w_merge_data[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge_data[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and memory/handshake strobes; reset masks the write strobe at once
  always_comb begin
    w_next_state     = r_state;
    Req_Ready        = 1'b0;
    Rsp_Valid        = 1'b0;
    Mem_Write_Enable = 1'b0;
    Mem_Write_Data   = '0;
    case (r_state)
      S_IDLE: begin
        Req_Ready = 1'b1;
        if (Req_Valid) begin
          w_next_state = w_req_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_write && (r_size == SZ_WORD)) begin
          Mem_Write_Enable = 1'b1;
          Mem_Write_Data   = r_wdata;
          w_next_state     = S_RESP;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (r_write) begin
          Mem_Write_Enable = 1'b1;
          Mem_Write_Data   = w_merge_data;
        end
        w_next_state = S_RESP;
      end
      S_RESP: begin
        Rsp_Valid    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (reset) begin
      Mem_Write_Enable = 1'b0;
    end
  end

  // Capture the request on accept and the load result in DATA
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_write  <= Req_Write;
      r_size   <= Req_Size;
      r_signed <= Req_Signed;
      r_addr   <= w_addr_eff;
      r_wdata  <= Req_Wdata;
      r_rdata  <= '0;
      r_err    <= w_req_err;
    end else if ((r_state == S_DATA) && !r_write) begin
      r_rdata <= w_load_data;
    end
  end

  assign Mem_Address = r_addr >> 2;
  assign Rsp_Data    = (r_state == S_RESP) ? r_rdata : '0;
  assign Rsp_Error   = (r_state == S_RESP) ? r_err : 1'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural memory model
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int DEPTH = 64;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Req_Valid = 1'b0;
  logic          Req_Ready;
  logic          Req_Write = 1'b0;
  logic [1:0]    Req_Size = 2'b00;
  logic          Req_Signed = 1'b0;
  logic [DW-1:0] Req_Address = '0;
  logic [DW-1:0] Req_Wdata = '0;
  logic          Rsp_Valid;
  logic [DW-1:0] Rsp_Data;
  logic          Rsp_Error;
  logic          Mem_Write_Enable;
  logic [DW-1:0] Mem_Address;
  logic [DW-1:0] Mem_Write_Data;
  logic [DW-1:0] Mem_Read_Data;

  always #5 clk = ~clk;

  load_store_unit #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .Req_Valid        (Req_Valid),
    .Req_Ready        (Req_Ready),
    .Req_Write        (Req_Write),
    .Req_Size         (Req_Size),
    .Req_Signed       (Req_Signed),
    .Req_Address      (Req_Address),
    .Req_Wdata        (Req_Wdata),
    .Rsp_Valid        (Rsp_Valid),
    .Rsp_Data         (Rsp_Data),
    .Rsp_Error        (Rsp_Error),
    .Mem_Write_Enable (Mem_Write_Enable),
    .Mem_Address      (Mem_Address),
    .Mem_Write_Data   (Mem_Write_Data),
    .Mem_Read_Data    (Mem_Read_Data)
  );

  // Memory attached to the DUT, with a backdoor used only while loading contents
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] mem_rdata;
  logic        bd_we = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (Mem_Write_Enable && (Mem_Address < DEPTH)) begin
      mem[Mem_Address[5:0]] <= Mem_Write_Data;
    end
    mem_rdata <= (Mem_Address < DEPTH) ? mem[Mem_Address[5:0]] : 32'h0;
  end
  assign Mem_Read_Data = mem_rdata;

  // Scoreboard state
  typedef struct { logic [31:0] data; logic err; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  rsp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] last_data;
  logic        last_err;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  rsp_t        mon_e;
  wr_t         mon_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (Rsp_Valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", Rsp_Data, mon_e.data);
        chk("rsp_error", {31'd0, Rsp_Error}, {31'd0, mon_e.err});
        chk("rsp_cycle", cyc, mon_e.cyc);
        last_data = Rsp_Data;
        last_err  = Rsp_Error;
      end
    end
  end

  // Memory write monitor
  always @(negedge clk) begin
    if (Mem_Write_Enable) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", Mem_Address, mon_w.addr);
        chk("wr_data", Mem_Write_Data, mon_w.data);
        last_wr_addr = Mem_Address;
        last_wr_data = Mem_Write_Data;
      end
    end
  end

  // Reference model plus driver for one request
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a_in, input logic [31:0] wd);
    rsp_t        e;
    wr_t         wr;
    logic [31:0] a, idx, word, v, mask;
    int          off, lat;
    logic        err;
    a   = a_in;
    idx = a / 4;
    err = (sz == 2'd3) || (idx >= DEPTH);
`ifdef LSU_ALIGN_CHECK_EN
    if (sz == 2'd1 && (a % 2) != 0) err = 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) err = 1'b1;
`else
    if (sz == 2'd1) a = a - (a % 2);
    if (sz == 2'd2) a = a - (a % 4);
`endif
    e.data = 32'h0;
    e.err  = err;
    lat    = 1;
    if (!err) begin
      word = ref_mem[idx];
      off  = int'(a % 4);
      if (!w) begin
        lat = 3;
        if (sz == 2'd0) begin
          v = (word >> (8 * off)) & 32'hFF;
          if (sg && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          v = (word >> (8 * off)) & 32'hFFFF;
          if (sg && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
          v = word;
        end
        e.data = v;
      end else begin
        if (sz == 2'd2) begin
          lat  = 2;
          word = wd;
        end else begin
          lat  = 3;
          mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
          word = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        end
        ref_mem[idx] = word;
        wr.addr = idx;
        wr.data = word;
        wr_q.push_back(wr);
      end
    end
    @(posedge clk); #1;
    Req_Valid   = 1'b1;
    Req_Write   = w;
    Req_Size    = sz;
    Req_Signed  = sg;
    Req_Address = a_in;
    Req_Wdata   = wd;
    @(negedge clk);
    chk("req_ready", {31'd0, Req_Ready}, 32'd1);
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    Req_Valid   = 1'b0;
    Req_Write   = 1'($urandom_range(0, 1));
    Req_Size    = 2'($urandom_range(0, 3));
    Req_Address = $urandom;
    Req_Wdata   = $urandom;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    chk("writes_drained", wr_q.size(), 32'd0);
    wr_q.delete();
  endtask

  // Half store interrupted by reset during its DATA cycle
  task automatic reset_in_data();
    @(posedge clk); #1;
    Req_Valid   = 1'b1;
    Req_Write   = 1'b1;
    Req_Size    = 2'd1;
    Req_Signed  = 1'b0;
    Req_Address = 32'h22;
    Req_Wdata   = 32'h0000_A5A5;
    @(posedge clk); #1;
    Req_Valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("we_forced_low_in_reset", {31'd0, Mem_Write_Enable}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, Req_Ready}, 32'd1);
    chk("no_rsp_after_reset", {31'd0, Rsp_Valid}, 32'd0);
    chk("addr_after_reset", Mem_Address, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          r;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h1234_5678;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      bd_we   = 1'b1;
      bd_addr = 6'(i);
      bd_data = ref_mem[i];
    end
    @(posedge clk); #1;
    bd_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, Req_Ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, Rsp_Valid}, 32'd0);
    chk("rst_rsp_error", {31'd0, Rsp_Error}, 32'd0);
    chk("rst_rsp_data", Rsp_Data, 32'd0);
    chk("rst_mem_we", {31'd0, Mem_Write_Enable}, 32'd0);
    chk("rst_mem_addr", Mem_Address, 32'd0);
    chk("rst_mem_wdata", Mem_Write_Data, 32'd0);

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("word_store_err", {31'd0, last_err}, 32'd0);
    chk("word_store_addr", last_wr_addr, 32'd4);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    chk("signed_byte_load", last_data, 32'hFFFF_FFDE);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    chk("unsigned_half_load", last_data, 32'h0000_BEEF);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h55);
    chk("byte_merge_data", last_wr_data, 32'hDEAD_55EF);
    chk("byte_merge_addr", last_wr_addr, 32'd4);
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    chk("out_of_range_err", {31'd0, last_err}, 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("misaligned_word_err", {31'd0, last_err}, 32'd1);
`else
    chk("misaligned_word_err", {31'd0, last_err}, 32'd0);
    chk("misaligned_word_data", last_data, 32'hDEAD_55EF);
`endif
    issue(1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
    chk("reserved_size_err", {31'd0, last_err}, 32'd1);

    reset_in_data();
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);

    for (int n = 0; n < 300; n++) begin
      r  = int'($urandom_range(0, 15));
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 1023)) : 32'($urandom_range(0, 255));
      wd = $urandom;
      issue(w, sz, sg, a, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
